// File: rtl/spi_host_tx.sv
// SPI mode-0 host transmitter: accepts bytes over valid/ready, shifts them out
// MSB first on COPI, frames consecutive bytes under one chip-select assertion
// and releases chip-select after the byte flagged last.
module spi_host_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8,
  parameter int BYTE_GAP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       SCLK,
  output logic       COPI,
  output logic       spi_cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_bytes
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, GAP, HOLD, CS_WAIT
  } state_t;

  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_M1  = 16'(CS_IDLE - 1);
  localparam logic [15:0] GAP_M1   = 16'(BYTE_GAP - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic        last_q, last_d;
  logic [7:0]  shift_reg, shift_d;
  logic [7:0]  frame_bytes_d;
  logic        tx_ready_d, sclk_d, copi_d, cs_n_d, busy_d, done_d;
  logic        xfer;

  // Byte counter stops at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign xfer = tx_valid & tx_ready;

  // Next-state, phase counter and next-output decode; outputs follow state_d
  // so every pin comes straight from a flop.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt + 16'd1;
    bit_cnt_d     = bit_cnt;
    last_d        = last_q;
    shift_d       = shift_reg;
    frame_bytes_d = frame_bytes;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          shift_d       = tx_data;
          last_d        = tx_last;
          frame_bytes_d = 8'd0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_M1) begin
          state_d   = LOW;
          cnt_d     = '0;
          bit_cnt_d = 3'd7;
        end
      end
      LOW: begin
        if (cnt == DIV_M1) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (cnt == DIV_M1) begin
          cnt_d = '0;
          if (bit_cnt != 3'd0) begin
            // Shift as SCLK falls so COPI never moves while SCLK is high.
            shift_d   = {shift_reg[6:0], 1'b0};
            bit_cnt_d = bit_cnt - 3'd1;
            state_d   = LOW;
          end else begin
            frame_bytes_d = sat_inc8(frame_bytes);
            state_d       = last_q ? HOLD : GAP;
          end
        end
      end
      GAP: begin
        // Counter parks at the last gap cycle; the frame stays open until
        // the next byte arrives.
        if (cnt == GAP_M1) cnt_d = cnt;
        if (xfer) begin
          shift_d   = tx_data;
          last_d    = tx_last;
          bit_cnt_d = 3'd7;
          cnt_d     = '0;
          state_d   = LOW;
        end
      end
      HOLD: begin
        if (cnt == HOLD_M1) begin
          state_d = CS_WAIT;
          cnt_d   = '0;
        end
      end
      CS_WAIT: begin
        if (cnt == IDLE_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sclk_d     = (state_d == HIGH);
    cs_n_d     = (state_d == IDLE) || (state_d == CS_WAIT);
    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE) || ((state_d == GAP) && (cnt_d == GAP_M1));
    done_d     = (state == HOLD) && (state_d == CS_WAIT);
    copi_d     = cs_n_d ? COPI : shift_d[7];
  end

  // Control state and registered outputs; async reset returns pins to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      last_q      <= 1'b0;
      frame_bytes <= 8'd0;
      tx_ready    <= 1'b0;
      SCLK        <= 1'b0;
      COPI        <= 1'b0;
      spi_cs_n    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_cnt     <= bit_cnt_d;
      last_q      <= last_d;
      frame_bytes <= frame_bytes_d;
      tx_ready    <= tx_ready_d;
      SCLK        <= sclk_d;
      COPI        <= copi_d;
      spi_cs_n    <= cs_n_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Data shift register; holds whatever byte is in flight.
  always_ff @(posedge clk) begin
    shift_reg <= shift_d;
  end

endmodule

// File: tb/tb_spi_host_tx.sv
// Directed bench for spi_host_tx: default-timing instance (dut0) and a
// CLK_DIV=1 instance (dut1). Monitors capture COPI on SCLK rising edges.
module tb_spi_host_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data  [2];
  logic       tx_last  [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       sclk     [2];
  logic       copi     [2];
  logic       cs_n     [2];
  logic       busy     [2];
  logic       done     [2];
  logic [7:0] fb       [2];

  spi_host_tx #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_last(tx_last[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .SCLK(sclk[0]),
    .COPI(copi[0]), .spi_cs_n(cs_n[0]), .busy(busy[0]), .done(done[0]),
    .frame_bytes(fb[0])
  );

  spi_host_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_last(tx_last[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .SCLK(sclk[1]),
    .COPI(copi[1]), .spi_cs_n(cs_n[1]), .busy(busy[1]), .done(done[1]),
    .frame_bytes(fb[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // dut0 monitor state
  bit   bits0[$];
  int   runs0[$];
  logic sp0 = 1'b0, cp0 = 1'b1;
  int   lr0 = 0, cr0 = 0, cs_len0 = 0, done_cnt0 = 0;
  logic done_rise0 = 1'b0;
  // dut1 monitor state
  bit   bits1[$];
  int   runs1[$];
  logic sp1 = 1'b0;
  int   lr1 = 0;

  // Capture bits at SCLK rises, SCLK-low run lengths, cs_n-low length, done.
  always @(negedge clk) begin
    if (!rst_n) begin
      sp0 <= 1'b0; cp0 <= 1'b1; lr0 <= 0; cr0 <= 0;
    end else begin
      sp0 <= sclk[0];
      cp0 <= cs_n[0];
      if (sclk[0] && !sp0) begin
        bits0.push_back(copi[0]);
        runs0.push_back(lr0);
      end
      lr0 <= (!sclk[0] && !cs_n[0]) ? lr0 + 1 : 0;
      if (!cs_n[0]) cr0 <= cr0 + 1;
      else if (!cp0) begin
        cs_len0 <= cr0;
        cr0     <= 0;
      end
      if (done[0]) begin
        done_cnt0  <= done_cnt0 + 1;
        done_rise0 <= cs_n[0] && !cp0;
      end
    end
  end

  // Same capture for the CLK_DIV=1 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      sp1 <= 1'b0; lr1 <= 0;
    end else begin
      sp1 <= sclk[1];
      if (sclk[1] && !sp1) begin
        bits1.push_back(copi[1]);
        runs1.push_back(lr1);
      end
      lr1 <= (!sclk[1] && !cs_n[1]) ? lr1 + 1 : 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at0(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits0[s+i];
    return b;
  endfunction

  function automatic logic [7:0] byte_at1(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits1[s+i];
    return b;
  endfunction

  // Offer a byte and return at the first negedge after it was accepted.
  task automatic send(input int u, input logic [7:0] d, input logic l, input bit hold);
    int t;
    t = 0;
    tx_data[u] = d; tx_last[u] = l; tx_valid[u] = 1'b1;
    while (!tx_ready[u] && t < 4000) begin @(negedge clk); t++; end
    check("send_accept", 32'(t < 4000), 32'd1);
    @(negedge clk);
    if (!hold) tx_valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int t;
    t = 0;
    while (!done[u] && t < 20000) begin @(negedge clk); t++; end
    check("done_seen", 32'(t < 20000), 32'd1);
  endtask

  task automatic wait_ready(input int u);
    int t;
    t = 0;
    while (!tx_ready[u] && t < 1000) begin @(negedge clk); t++; end
    check("ready_seen", 32'(t < 1000), 32'd1);
  endtask

  initial begin
    int b, r, dc, n, t, errs;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      tx_data[u] = 8'h00; tx_last[u] = 1'b0; tx_valid[u] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_pins", 32'({tx_ready[0], sclk[0], copi[0], cs_n[0], busy[0], done[0]}), 32'b000100);
    check("reset_fb", 32'(fb[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'({tx_ready[0], busy[0]}), 32'b10);

    // Single-byte frame 0xA5
    b = bits0.size(); dc = done_cnt0;
    send(0, 8'hA5, 1'b1, 1'b0);
    wait_done(0);
    #1;
    check("a5_cs_low_len", 32'(cs_len0), 32'd72);
    check("a5_done_at_cs_rise", 32'(done_rise0), 32'd1);
    check("a5_fb", 32'(fb[0]), 32'd1);
    n = 0;
    while (!tx_ready[0] && n < 100) begin @(negedge clk); n++; end
    check("a5_ready_delay", 32'(n), 32'd8);
    check("a5_done_count", 32'(done_cnt0 - dc), 32'd1);
    check("a5_nbits", 32'(bits0.size() - b), 32'd8);
    check("a5_bits", 32'(byte_at0(b)), 32'hA5);

    // Three-byte frame with tx_valid held high
    b = bits0.size(); r = runs0.size();
    send(0, 8'h3C, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h00, 1'b1, 1'b0);
    wait_done(0);
    #1;
    check("multi_nbits", 32'(bits0.size() - b), 32'd24);
    check("multi_b0", 32'(byte_at0(b)), 32'h3C);
    check("multi_b1", 32'(byte_at0(b + 8)), 32'hFF);
    check("multi_b2", 32'(byte_at0(b + 16)), 32'h00);
    check("multi_first_low", 32'(runs0[r]), 32'd8);
    check("multi_bit_low", 32'(runs0[r + 1]), 32'd4);
    // inter-byte low run = BYTE_GAP gap cycles + CLK_DIV low half of bit 7
    check("multi_gap1_low", 32'(runs0[r + 8]), 32'd12);
    check("multi_gap2_low", 32'(runs0[r + 16]), 32'd12);
    check("multi_cs_low_len", 32'(cs_len0), 32'd216);
    check("multi_fb", 32'(fb[0]), 32'd3);

    // Back-pressure with an ignored offer during HIGH
    b = bits0.size(); dc = done_cnt0;
    send(0, 8'h12, 1'b0, 1'b0);
    t = 0;
    while (!sclk[0] && t < 100) begin @(negedge clk); t++; end
    tx_data[0] = 8'hEE; tx_last[0] = 1'b1; tx_valid[0] = 1'b1;
    check("bp_ready_in_high", 32'(tx_ready[0]), 32'd0);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_ready(0);
    repeat (100) @(negedge clk);
    #1;
    check("bp_pause_pins", 32'({sclk[0], cs_n[0], busy[0], tx_ready[0]}), 32'b0011);
    check("bp_pause_nbits", 32'(bits0.size() - b), 32'd8);
    check("bp_pause_no_done", 32'(done_cnt0 - dc), 32'd0);
    send(0, 8'h34, 1'b1, 1'b0);
    wait_done(0);
    #1;
    check("bp_nbits", 32'(bits0.size() - b), 32'd16);
    check("bp_b0", 32'(byte_at0(b)), 32'h12);
    check("bp_b1", 32'(byte_at0(b + 8)), 32'h34);
    check("bp_fb", 32'(fb[0]), 32'd2);

    // Reset in the middle of 0x81
    wait_ready(0);
    b = bits0.size(); dc = done_cnt0;
    send(0, 8'h81, 1'b1, 1'b0);
    t = 0;
    while ((bits0.size() - b) < 3 && t < 1000) begin @(negedge clk); #1; t++; end
    check("rst_third_rise", 32'(t < 1000), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_pins", 32'({cs_n[0], sclk[0], copi[0], busy[0], done[0], tx_ready[0]}), 32'b100000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_done", 32'(done_cnt0 - dc), 32'd0);
    check("rst_cs_idle", 32'(cs_n[0]), 32'd1);
    b = bits0.size();
    send(0, 8'h81, 1'b1, 1'b0);
    wait_done(0);
    #1;
    check("rst_refresh_nbits", 32'(bits0.size() - b), 32'd8);
    check("rst_refresh_bits", 32'(byte_at0(b)), 32'h81);
    check("rst_refresh_fb", 32'(fb[0]), 32'd1);

    // Image load: one command byte plus 113 image bytes in one frame
    b = bits0.size();
    send(0, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 113; i++) send(0, 8'(i * 7 + 1), 1'(i == 112), i != 112);
    wait_done(0);
    #1;
    check("img_nbits", 32'(bits0.size() - b), 32'd912);
    errs = 0;
    if (byte_at0(b) !== 8'hC3) errs++;
    for (int i = 0; i < 113; i++) if (byte_at0(b + 8 + 8 * i) !== 8'(i * 7 + 1)) errs++;
    check("img_byte_errors", 32'(errs), 32'd0);
    check("img_fb", 32'(fb[0]), 32'd114);

    // CLK_DIV=1 instance: 0x55, then frame_bytes saturation
    b = bits1.size(); r = runs1.size();
    send(1, 8'h55, 1'b1, 1'b0);
    wait_done(1);
    #1;
    check("div1_nbits", 32'(bits1.size() - b), 32'd8);
    check("div1_bits", 32'(byte_at1(b)), 32'h55);
    check("div1_first_low", 32'(runs1[r]), 32'd5);
    check("div1_bit_low", 32'(runs1[r + 1]), 32'd1);
    for (int i = 0; i < 260; i++) send(1, 8'(i), 1'(i == 259), i != 259);
    wait_done(1);
    #1;
    check("div1_fb_saturate", 32'(fb[1]), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
